i2c_scl_timing_gen: RTL and testbench

- Next-generation SCL timing source for the I2C master. Replaces the fixed-DELAY divider.
- Divides ref_clk into four equal quarter-phases per bit period. The quarter length is programmable at runtime.
- Drives SCL open-drain, honours slave clock stretching with a timeout, and emits one-cycle phase strobes for the byte/bit FSM.

---
 rtl/i2c_scl_timing_gen.sv | 104 ++++++++++
 tb/tb_i2c_scl_timing_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_timing_gen.sv
// i2c_scl_timing_gen: quarter-phase SCL generator with clock stretching, stretch timeout and phase strobes
//   ref_clk/reset_n : clock, async active-low reset
//   run, div_q      : period request level, quarter length (clamped to MIN_Q, latched at period start)
//   scl_in          : raw SCL pad, synchronised internally
//   scl_oe, busy    : open-drain low drive, period in progress
//   tick_*          : one-cycle phase strobes; period_done at each period end
//   stretching      : counter held by slave; timeout_err sticky until next start
module i2c_scl_timing_gen #(
  parameter int CW = 12,
  parameter int TO_W = 16,
  parameter int STRETCH_TIMEOUT = 25000,
  parameter int MIN_Q = 4
) (
  input  logic          ref_clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic [CW-1:0] div_q,
  input  logic          scl_in,
  output logic          scl_oe,
  output logic          busy,
  output logic          tick_change,
  output logic          tick_rise,
  output logic          tick_sample,
  output logic          tick_fall,
  output logic          period_done,
  output logic          stretching,
  output logic          timeout_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0] st;
  logic [1:0] ph;
  logic [CW-1:0] cnt, q, q_nxt;
  logic [TO_W-1:0] to_cnt;
  logic s1, s2, hold, tmo;
  assign q_nxt = div_q < CW'(MIN_Q) ? CW'(MIN_Q) : div_q;
  // cnt==3 in ph2 leaves time for our own release to pass the synchroniser
  assign hold = st == RUN && ph == 2'd2 && cnt == CW'(3) && !s2;
  assign tmo = hold && to_cnt == TO_W'(STRETCH_TIMEOUT - 1);
  always_ff @(posedge ref_clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      ph <= '0;
      cnt <= '0;
      q <= CW'(MIN_Q);
      to_cnt <= '0;
      s1 <= 1'b1;
      s2 <= 1'b1;
      scl_oe <= 1'b0;
      busy <= 1'b0;
      tick_change <= 1'b0;
      tick_rise <= 1'b0;
      tick_sample <= 1'b0;
      tick_fall <= 1'b0;
      period_done <= 1'b0;
      stretching <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      s1 <= scl_in;
      s2 <= s1;
      tick_change <= 1'b0;
      tick_rise <= 1'b0;
      tick_sample <= 1'b0;
      tick_fall <= 1'b0;
      period_done <= 1'b0;
      stretching <= hold && !tmo;
      to_cnt <= (hold && !tmo) ? to_cnt + TO_W'(1) : '0;
      if (st == IDLE) begin
        if (run) begin
          st <= RUN;
          ph <= '0;
          cnt <= '0;
          busy <= 1'b1;
          scl_oe <= 1'b1;
          q <= q_nxt;
          timeout_err <= 1'b0;
        end
      end else if (tmo) begin
        st <= IDLE;
        ph <= '0;
        cnt <= '0;
        busy <= 1'b0;
        scl_oe <= 1'b0;
        timeout_err <= 1'b1;
      end else if (!hold) begin
        if (cnt != q - CW'(1)) cnt <= cnt + CW'(1);
        else begin
          cnt <= '0;
          ph <= ph + 2'd1;
          tick_change <= ph == 2'd0;
          tick_rise <= ph == 2'd1;
          tick_sample <= ph == 2'd2;
          scl_oe <= ph == 2'd0 || (ph == 2'd3 && run);
          if (ph == 2'd3) begin
            period_done <= 1'b1;
            tick_fall <= run;
            q <= q_nxt;
            busy <= run;
            st <= run ? RUN : IDLE;
          end
        end
      end
    end
endmodule

// File: tb/tb_i2c_scl_timing_gen.sv
// tb_i2c_scl_timing_gen: directed and random checks of i2c_scl_timing_gen against a period-offset model
module tb_i2c_scl_timing_gen;
  localparam int CW = 12;
  localparam int TO = 100;
  localparam int MINQ = 4;
  logic ref_clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic scl_in = 1'b1;
  logic [CW-1:0] div_q = 12'd125;
  logic scl_oe, busy, tick_change, tick_rise, tick_sample, tick_fall, period_done, stretching, timeout_err;
  int n_chk = 0;
  int n_pass = 0;
  bit slave_hold = 1'b0;
  bit m_act, m_err, m_s1, m_s2;
  int m_off, m_q, m_hold;
  bit e_oe, e_chg, e_rise, e_smp, e_fall, e_done, e_str;

  i2c_scl_timing_gen #(.CW(CW), .TO_W(16), .STRETCH_TIMEOUT(TO), .MIN_Q(MINQ)) dut (
    .ref_clk(ref_clk), .reset_n(reset_n), .run(run), .div_q(div_q), .scl_in(scl_in),
    .scl_oe(scl_oe), .busy(busy), .tick_change(tick_change), .tick_rise(tick_rise),
    .tick_sample(tick_sample), .tick_fall(tick_fall), .period_done(period_done),
    .stretching(stretching), .timeout_err(timeout_err)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, want, $time);
  endtask

  task automatic model_reset();
    m_act = 0; m_err = 0; m_s1 = 1; m_s2 = 1; m_off = 0; m_q = MINQ; m_hold = 0;
    {e_oe, e_chg, e_rise, e_smp, e_fall, e_done, e_str} = '0;
  endtask

  // Position within the period is a single offset; a stretch freezes it at 2q+3.
  task automatic model_step();
    bit sy, adv;
    int cq;
    sy = m_s2; m_s2 = m_s1; m_s1 = scl_in;
    {e_chg, e_rise, e_smp, e_fall, e_done, e_str} = '0;
    adv = 0;
    cq = int'(div_q) < MINQ ? MINQ : int'(div_q);
    if (!m_act) begin
      m_hold = 0;
      if (run) begin m_act = 1; m_off = 0; m_q = cq; m_err = 0; end
    end else if (m_off == 2 * m_q + 3 && !sy) begin
      m_hold++;
      if (m_hold == TO) begin m_act = 0; m_err = 1; m_hold = 0; m_off = 0; end
      else e_str = 1;
    end else begin
      m_hold = 0; m_off++; adv = 1;
      if (m_off == 4 * m_q) begin
        e_done = 1;
        if (run) begin m_off = 0; e_fall = 1; m_q = cq; end
        else begin m_act = 0; m_off = 0; end
      end
    end
    e_chg = adv && m_act && m_off == m_q;
    e_rise = adv && m_act && m_off == 2 * m_q;
    e_smp = adv && m_act && m_off == 3 * m_q;
    e_oe = m_act && m_off < 2 * m_q;
  endtask

  task automatic check_all();
    chk("scl_oe", scl_oe, e_oe);
    chk("busy", busy, m_act);
    chk("tick_change", tick_change, e_chg);
    chk("tick_rise", tick_rise, e_rise);
    chk("tick_sample", tick_sample, e_smp);
    chk("tick_fall", tick_fall, e_fall);
    chk("period_done", period_done, e_done);
    chk("stretching", stretching, e_str);
    chk("timeout_err", timeout_err, m_err);
  endtask

  task automatic step();
    scl_in = !e_oe && !slave_hold;
    @(posedge ref_clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic measure(input string tag, input int want);
    int n = 0;
    do begin step(); n++; end while (!period_done && n < 2000);
    chk(tag, n, want);
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    do begin step(); n++; end while (!tick_rise && n < 2000);
    chk(tag, tick_rise, 1);
  endtask

  initial begin
    int n, nstr, nsmp;
    model_reset();
    repeat (3) @(posedge ref_clk);
    #1;
    check_all();
    reset_n = 1;
    div_q = 125; run = 1;
    measure("p125_first", 501);
    measure("p125", 500);
    div_q = 2;
    measure("p125_tail", 500);
    measure("p16", 16);
    repeat (8) step();
    div_q = 10;
    measure("p16_tail", 8);
    measure("p40", 40);
    repeat (12) step();
    run = 0;
    measure("stop_tail", 28);
    chk("stop_done", period_done, 1);
    chk("stop_no_fall", tick_fall, 0);
    chk("stop_busy", busy, 0);
    chk("stop_oe", scl_oe, 0);
    repeat (5) step();
    div_q = 20; run = 1;
    wait_rise("stretch_rise");
    slave_hold = 1;
    n = 0; nstr = 0; nsmp = 0;
    do begin
      if (n == 50) slave_hold = 0;
      step(); n++;
      nstr += int'(stretching);
      if (tick_sample) nsmp = n;
    end while (!period_done && n < 500);
    slave_hold = 0;
    chk("stretch_cycles", nstr, 49);
    chk("stretch_sample", nsmp, 69);
    chk("stretch_period", n, 89);
    chk("stretch_fall", tick_fall, 1);
    measure("after_stretch", 80);
    wait_rise("to_rise");
    slave_hold = 1;
    n = 0;
    do begin
      if (n == 10) run = 0;
      step(); n++;
    end while (busy && n < 400);
    slave_hold = 0;
    chk("to_latency", n, 103);
    chk("to_err", timeout_err, 1);
    chk("to_oe", scl_oe, 0);
    chk("to_no_done", period_done, 0);
    repeat (3) step();
    chk("to_sticky", timeout_err, 1);
    run = 1;
    step();
    chk("to_clear", timeout_err, 0);
    chk("to_restart", busy, 1);
    wait_rise("rst_rise");
    slave_hold = 1;
    repeat (10) step();
    chk("rst_pre_stretch", stretching, 1);
    #2 reset_n = 0;
    #1;
    {run, slave_hold} = '0;
    model_reset();
    check_all();
    #1 reset_n = 1;
    repeat (10) step();
    chk("rst_idle", busy, 0);
    chk("rst_err", timeout_err, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < (run ? 1 : 5)) run = !run;
      if ($urandom_range(0, 49) == 0) div_q = CW'($urandom_range(0, 40));
      if (!slave_hold && $urandom_range(0, 49) == 0) slave_hold = 1;
      else if (slave_hold && $urandom_range(0, 7) == 0) slave_hold = 0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
